// File: rtl/pipe_squash_pkg.sv
// Shared constants for the pipeline squash controller: default counter width
// and the standard bubble penalties for control-flow redirects.
package pipe_squash_pkg;

    localparam int CNT_W_DEF = 3;

    localparam int PEN_BRANCH = 3;
    localparam int PEN_JUMP   = 3;
    localparam int PEN_JREG   = 4;

endpackage

// File: rtl/squash_req_max.sv
// Masked maximum over the squash request lengths; a source contributes only
// while its valid bit is high, and the result is zero when no source is valid.
module squash_req_max #(
    parameter int NSRC  = 3,
    parameter int CNT_W = 3
) (
    input  logic [NSRC-1:0]       req_vld,
    input  logic [NSRC*CNT_W-1:0] req_len,
    output logic [CNT_W-1:0]      req_max
);

    always_comb begin
        req_max = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (req_vld[i] && (req_len[i*CNT_W +: CNT_W] > req_max))
                req_max = req_len[i*CNT_W +: CNT_W];
        end
    end

endmodule

// File: rtl/pipe_squash_ctrl.sv
// Bubble counter for pipeline squashing: the longest outstanding request wins,
// force_vld overrides everything, and a saturating counter tracks squash cycles.
module pipe_squash_ctrl
    import pipe_squash_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int NSRC   = 3,
    parameter int PERF_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [NSRC-1:0]       req_vld,
    input  logic [NSRC*CNT_W-1:0] req_len,
    input  logic                  force_vld,
    input  logic [CNT_W-1:0]      force_len,
    input  logic                  perf_clr,
    output logic [CNT_W-1:0]      cnt,
    output logic                  squash,
    output logic [PERF_W-1:0]     perf_squash
);

    logic [CNT_W-1:0] req_max;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] cnt_nxt;

    squash_req_max #(
        .NSRC  (NSRC),
        .CNT_W (CNT_W)
    ) u_req_max (
        .req_vld (req_vld),
        .req_len (req_len),
        .req_max (req_max)
    );

    // A stalled pipeline holds the count, so requests compare against it undecremented.
    always_comb begin
        base = cnt;
        if (!stall && (cnt != '0))
            base = cnt - CNT_W'(1);
    end

    always_comb begin
        cnt_nxt = (req_max > base) ? req_max : base;
        if (force_vld)
            cnt_nxt = force_len;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

    assign squash = (cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_squash <= '0;
        else if (perf_clr)
            perf_squash <= '0;
        else if (squash && !stall && (perf_squash != '1))
            perf_squash <= perf_squash + PERF_W'(1);
    end

endmodule
